// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: instruction-memory port, IF/ID output handshake,
// redirect input and fault/status outputs bundled into one interface.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_instr;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc4;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              fault;
    logic [ADDR_W-1:0] fault_addr;
    logic [15:0]       fetch_count;

    // Sequencer side of the bus
    modport master (
        output imem_addr,
        input  imem_instr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc4,
        input  redirect_valid,
        input  redirect_target,
        output fault,
        output fault_addr,
        output fetch_count
    );

    // Memory / pipeline side of the bus
    modport slave (
        input  imem_addr,
        output imem_instr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc4,
        output redirect_valid,
        output redirect_target,
        input  fault,
        input  fault_addr,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads the combinational
// instruction memory, presents words to IF/ID over valid/ready, applies
// redirects and traps misaligned or out-of-range fetch addresses.
module fetch_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter int                MEM_WORDS = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.master bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS * 4);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              out_valid;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] fault_addr;
    logic [15:0]       fetch_count;

    logic transfer;
    logic target_bad;
    logic can_load;
    logic pc_out_of_range;

    // Handshake, redirect legality and load-opportunity decode
    always_comb begin
        transfer        = out_valid & bus.out_ready;
        target_bad      = (bus.redirect_target[1:0] != 2'b00) ||
                          (bus.redirect_target >= MEM_LIMIT);
        can_load        = (state == ST_FETCH) && (!out_valid || bus.out_ready);
        pc_out_of_range = (pc >= MEM_LIMIT);
    end

    // Sequencer state, PC and output register; redirect overrides every state
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_pc     <= '0;
            fault_addr <= '0;
        end else if (bus.redirect_valid) begin
            out_valid <= 1'b0;
            if (target_bad) begin
                state      <= ST_FAULT;
                fault_addr <= bus.redirect_target;
            end else begin
                pc    <= bus.redirect_target;
                state <= ST_FETCH;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (can_load) begin
                        if (pc_out_of_range) begin
                            state      <= ST_FAULT;
                            fault_addr <= pc;
                            out_valid  <= 1'b0;
                        end else begin
                            out_instr <= bus.imem_instr;
                            out_pc    <= pc;
                            out_valid <= 1'b1;
                            pc        <= pc + WORD_STEP;
                        end
                    end
                end
                ST_FAULT: begin
                    out_valid <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Count accepted transfers, sticking at the top value
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (transfer && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.out_valid   = out_valid;
    assign bus.out_instr   = out_instr;
    assign bus.out_pc      = out_pc;
    assign bus.out_pc4     = out_pc + WORD_STEP;
    assign bus.fault       = (state == ST_FAULT);
    assign bus.fault_addr  = fault_addr;
    assign bus.fetch_count = fetch_count;
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the single-clock MIPS pipeline. It owns the program counter, drives the address of the combinational word-addressed instruction memory, and presents fetched words to the IF/ID stage through a valid/ready handshake. It also applies branch/jump redirects from later stages and traps fetch faults: misaligned target or address beyond the memory.

## Interface
- `ADDR_W`, 32: PC and address width.
- `MEM_WORDS`, 64: instruction memory depth in words; legal byte addresses are 0 .. MEM_WORDS*4-4.
- `RESET_PC`, 0: PC value after reset.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `imem_addr` output ADDR_W: byte address to instruction memory; equals the PC register (combinational from register).
- `imem_instr` input 32: instruction word returned combinationally for `imem_addr`.
- `out_valid` output 1: output register holds an instruction.
- `out_ready` input 1: IF/ID accepts; transfer when `out_valid & out_ready`.
- `out_instr` output 32: registered instruction.
- `out_pc` output ADDR_W: address of `out_instr`.
- `out_pc4` output ADDR_W: `out_pc + 4` (modulo 2^ADDR_W).
- `redirect_valid` input 1: branch/jump taken; load new PC.
- `redirect_target` input ADDR_W: byte target address.
- `fault` output 1: sequencer is in FAULT.
- `fault_addr` output ADDR_W: offending address latched on fault entry.
- `fetch_count` output 16: accepted transfers, saturating at 0xFFFF.

## Operation
- States: IDLE, FETCH, FAULT.
- Reset values:
  - state IDLE, PC=RESET_PC.
  - out_valid=0, out_instr=0, out_pc=0.
  - fault=0, fault_addr=0, fetch_count=0.
- IDLE: one cycle, then FETCH unconditionally, unless a redirect arrives; a redirect in IDLE is handled as in FETCH.
- Output register loads in FETCH when it is empty or is being accepted this cycle, and no redirect is asserted.
  - Load: out_instr←imem_instr, out_pc←PC, out_valid←1, PC←PC+4.
- Output register holds in FETCH when `out_valid & ~out_ready`.
  - out_instr, out_pc and PC are all stable.
- An accepted transfer with no new load clears out_valid.
- Range check: if PC ≥ MEM_WORDS*4 when a load would occur, there is no load.
  - State→FAULT, fault_addr←PC.
  - A word already in the output register still completes its handshake normally.
- Redirect (`redirect_valid`), highest priority in every state:
  - A transfer completing in the same cycle counts: fetch_count increments.
  - out_valid←0, so the output register is flushed.
  - If target[1:0]≠0 or target ≥ MEM_WORDS*4: state→FAULT, fault_addr←target, PC unchanged.
  - Otherwise: PC←target, state→FETCH. A redirect from FAULT is the only recovery path, and it clears `fault`.
- FAULT behaviour:
  - out_valid=0; no loads; PC frozen.
  - fault=1 while in FAULT.
- fetch_count increments on every `out_valid & out_ready` cycle and saturates.
- Reset has priority over redirect and over any in-progress hold; all state returns to reset values on the next edge.

## Timing
- Reset released before edge E0:
  - E0: IDLE→FETCH.
  - E1: first load.
  - out_valid=1 from E1 onward, with out_pc=RESET_PC.
- Steady state with out_ready held high: one instruction per cycle, zero bubbles.
- Redirect latency:
  - `redirect_valid` sampled at edge En → out_valid=0 during cycle n+1.
  - Target instruction valid after En+1, so exactly one bubble.
- Backpressure takes effect in the same cycle; there is no skid.
- out_instr and out_pc must be stable throughout any cycle where `out_valid & ~out_ready`.
- Fault entry: fault=1 on the cycle after the offending edge decision.

## Test plan
- Reset sequence with out_ready=1 and imem preloaded with the test program:
  - Required: out_valid rises after E1 with out_pc=0x0, out_instr=0x20080020.
  - Next cycle: out_pc=0x4, out_instr=0x20090037.
  - After 8 cycles of streaming: fetch_count=8.
- Backpressure: out_ready=0 for 3 cycles while out_pc=0x8.
  - Required: out_pc=0x8 and out_instr stable; imem_addr stays 0xC.
  - After ready returns: out_pc=0xC next, and fetch_count increments once per accepted word only.
- Redirect to 0x5C in the same cycle as a completing transfer:
  - Required: that transfer is counted; one cycle with out_valid=0.
  - Then out_pc=0x5C, out_instr=0x0251A02A.
- Misaligned redirect to 0x5E:
  - Required: fault=1, fault_addr=0x5E, out_valid=0, PC held.
  - Then redirect 0x0: fault clears, and out_pc=0x0 appears one bubble later.
- Run-off-end with MEM_WORDS=64 and no redirects:
  - Word at 0xFC is delivered and accepted.
  - Then fault=1, fault_addr=0x100, and out_valid stays 0.
- Reset asserted mid-hold (out_valid=1, out_ready=0):
  - Required: next edge gives out_valid=0, out_pc=0, fetch_count=0, fault=0, imem_addr=RESET_PC.
